// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
// Holds FSM encoding, frame marker, frame IDs and bitmap bit indices.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    HUNT,
    GET_ID,
    GET_DATA,
    GET_CHK
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  localparam logic [7:0] ID_P1   = 8'h01;
  localparam logic [7:0] ID_P2   = 8'h02;
  localparam logic [7:0] ID_CTRL = 8'h10;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_FIRE  = 4;

  localparam int CTRL_START = 0;
  localparam int CTRL_PAUSE = 1;

  function automatic logic [7:0] sat_inc(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wdog_timer.sv
// Watchdog counter: counts while enable, stops at LIMIT-1 and holds there.
// Ports: clk, rstn (sync, active-low), clear, enable -> expired (held until clear).
module wdog_timer #(
  parameter int LIMIT = 100000
)(
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != LAST) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command-frame controller behind the UART receiver: frames A5/ID/DATA/CHK.
// In: clk, rstn, rx_data, rx_valid. Out: key bitmaps, ctrl pulses, errors, link_ok.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE     = 8'hA5,
  parameter int         BYTE_TIMEOUT = 100000,
  parameter int         LINK_TIMEOUT = 50000000
)(
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] p1_keys,
  output logic [7:0] p2_keys,
  output logic       start_pulse,
  output logic       pause_pulse,
  output logic       frame_err,
  output logic [7:0] err_cnt,
  output logic       link_ok
);

  state_t     state;
  logic [7:0] id;
  logic [7:0] data;
  logic       hunting;
  logic       good;
  logic       byte_exp;
  logic       link_exp;

  assign hunting = (state == HUNT);
  assign good    = (state == GET_CHK) && rx_valid
                && (rx_data == (id ^ data));

  wdog_timer #(.LIMIT(BYTE_TIMEOUT)) u_byte_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (rx_valid || hunting),
    .enable  (!hunting),
    .expired (byte_exp)
  );

  wdog_timer #(.LIMIT(LINK_TIMEOUT)) u_link_wdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (good),
    .enable  (1'b1),
    .expired (link_exp)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= HUNT;
      id          <= '0;
      data        <= '0;
      p1_keys     <= '0;
      p2_keys     <= '0;
      start_pulse <= 1'b0;
      pause_pulse <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= '0;
      link_ok     <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      pause_pulse <= 1'b0;
      frame_err   <= 1'b0;

      // Link loss drops keys; a good frame in the same cycle wins.
      if (link_exp && !good) begin
        link_ok <= 1'b0;
        p1_keys <= '0;
        p2_keys <= '0;
      end

      // A byte arriving on the timeout cycle wins over the timeout.
      if (!hunting && !rx_valid && byte_exp) begin
        state     <= HUNT;
        frame_err <= 1'b1;
        err_cnt   <= sat_inc(err_cnt);
      end else if (rx_valid) begin
        unique case (state)
          HUNT: begin
            if (rx_data == HDR_BYTE) state <= GET_ID;
          end
          GET_ID: begin
            id    <= rx_data;
            state <= GET_DATA;
          end
          GET_DATA: begin
            data  <= rx_data;
            state <= GET_CHK;
          end
          GET_CHK: begin
            state <= HUNT;
            if (good) begin
              link_ok <= 1'b1;
              unique case (1'b1)
                (id == ID_P1): p1_keys <= data;
                (id == ID_P2): p2_keys <= data;
                (id == ID_CTRL): begin
                  start_pulse <= data[CTRL_START];
                  pause_pulse <= data[CTRL_PAUSE];
                end
                default: ;
              endcase
            end else begin
              frame_err <= 1'b1;
              err_cnt   <= sat_inc(err_cnt);
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus queues expected output
// snapshots, a monitor pops one each time the DUT outputs change.
module tb_uart_cmd_ctrl;

  typedef struct packed {
    logic [7:0] p1;
    logic [7:0] p2;
    logic       start;
    logic       pause;
    logic       ferr;
    logic [7:0] err;
    logic       link;
  } obs_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] p1_keys;
  logic [7:0] p2_keys;
  logic       start_pulse;
  logic       pause_pulse;
  logic       frame_err;
  logic [7:0] err_cnt;
  logic       link_ok;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];
  obs_t m;
  obs_t prev;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .HDR_BYTE     (8'hA5),
    .BYTE_TIMEOUT (50),
    .LINK_TIMEOUT (200)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .p1_keys     (p1_keys),
    .p2_keys     (p2_keys),
    .start_pulse (start_pulse),
    .pause_pulse (pause_pulse),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt),
    .link_ok     (link_ok)
  );

  function automatic obs_t sample();
    obs_t o;
    o.p1    = p1_keys;
    o.p2    = p2_keys;
    o.start = start_pulse;
    o.pause = pause_pulse;
    o.ferr  = frame_err;
    o.err   = err_cnt;
    o.link  = link_ok;
    return o;
  endfunction

  // Monitor: any output change is one DUT event to score.
  always @(negedge clk) begin
    obs_t o;
    obs_t e;
    if (mon_en) begin
      o = sample();
      if (o !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event got=%h", o);
        end else begin
          e = exp_q.pop_front();
          if (o !== e) begin
            errors++;
            $display("FAIL event got=%h exp=%h", o, e);
          end
        end
      end
      prev = o;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic frame(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d
  );
    send(a);
    send(b);
    send(c);
    send(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push();
    exp_q.push_back(m);
  endtask

  task automatic push_err();
    m.err  = (m.err == 8'hFF) ? 8'hFF : m.err + 8'd1;
    m.ferr = 1'b1;
    push();
    m.ferr = 1'b0;
    push();
  endtask

  task automatic check(
    input string name,
    input logic [7:0] got,
    input logic [7:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  initial begin
    m    = '0;
    prev = '0;
    idle(3);
    check("reset_state", {p1_keys, p2_keys}, 8'h00);
    check("reset_flags",
          {1'b0, start_pulse, pause_pulse, frame_err,
           link_ok, 3'b000}, 8'h00);
    check("reset_err", err_cnt, 8'h00);
    rstn = 1'b1;
    idle(1);
    mon_en = 1'b1;

    // Player 1 keys, checked directly on the latency cycle too.
    m.p1   = 8'h11;
    m.link = 1'b1;
    push();
    frame(8'hA5, 8'h01, 8'h11, 8'h10);
    check("p1_latency", p1_keys, 8'h11);
    idle(2);

    // Bad checksum, then the good version.
    push_err();
    frame(8'hA5, 8'h02, 8'h04, 8'h07);
    idle(2);
    m.p2 = 8'h04;
    push();
    frame(8'hA5, 8'h02, 8'h04, 8'h06);
    idle(2);

    // Start and pause in the same cycle.
    m.start = 1'b1;
    m.pause = 1'b1;
    push();
    m.start = 1'b0;
    m.pause = 1'b0;
    push();
    frame(8'hA5, 8'h10, 8'h03, 8'h13);
    idle(2);

    // Inter-byte timeout mid-frame, then recovery from HUNT.
    push_err();
    send(8'hA5);
    send(8'h01);
    idle(60);
    m.p1 = 8'h08;
    push();
    frame(8'hA5, 8'h01, 8'h08, 8'h09);
    idle(2);

    // Link loss clears both key maps.
    m.p1 = 8'h1F;
    push();
    frame(8'hA5, 8'h01, 8'h1F, 8'h1E);
    m.p1   = 8'h00;
    m.p2   = 8'h00;
    m.link = 1'b0;
    push();
    idle(210);
    check("link_lost", {7'd0, link_ok}, 8'h00);
    check("link_p1", p1_keys, 8'h00);

    // Error counter saturation.
    for (int i = 0; i < 260; i++) begin
      push_err();
      frame(8'hA5, 8'h01, 8'h00, 8'h55);
    end
    idle(2);
    check("err_sat", err_cnt, 8'hFF);

    // Reset mid-frame discards the partial frame.
    send(8'hA5);
    send(8'h01);
    m = '0;
    push();
    @(posedge clk);
    #1;
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    send(8'h01);
    send(8'h11);
    send(8'h10);
    idle(2);
    check("post_reset_p1", p1_keys, 8'h00);
    m.p1   = 8'h11;
    m.link = 1'b1;
    push();
    frame(8'hA5, 8'h01, 8'h11, 8'h10);
    idle(2);
    check("after_reset_p1", p1_keys, 8'h11);

    // Unknown ID: good frame, no output change.
    frame(8'hA5, 8'h33, 8'h44, 8'h77);
    idle(4);
    check("unknown_id_p1", p1_keys, 8'h11);

    idle(10);
    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command-frame controller that sits directly behind the UART receiver (115200 8N1, 100 MHz) in the tank game input path.
- Consumes the receiver's byte/valid stream and sequences bytes through a framing FSM.
- Validates a 4-byte frame and publishes registered player key bitmaps and game-control pulses to the game logic.
- Runs inter-byte and link-loss watchdogs so a dropped PC/remote link never leaves keys stuck pressed.

Parameters:
- HDR_BYTE, 8'hA5, frame start marker.
- BYTE_TIMEOUT, 100000, max clocks between bytes inside a frame (1 ms at 100 MHz).
- LINK_TIMEOUT, 50000000, clocks without a good frame before link is declared lost (0.5 s).

Ports:
- clk  in  1  100 MHz system clock.
- rstn  in  1  synchronous active-low reset.
- rx_data  in  8  received byte from UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- p1_keys  out  8  player 1 key bitmap (bit0 up, bit1 down, bit2 left, bit3 right, bit4 fire, bits7:5 reserved).
- p2_keys  out  8  player 2 key bitmap, same encoding.
- start_pulse  out  1  one-cycle game start request.
- pause_pulse  out  1  one-cycle pause-toggle request.
- frame_err  out  1  one-cycle pulse on checksum failure or in-frame timeout.
- err_cnt  out  8  saturating error count.
- link_ok  out  1  high while good frames arrive within LINK_TIMEOUT.

Behaviour:
- Reset values: all outputs 0; FSM in HUNT; both timers 0.
- Reset has priority over all other activity, including mid-frame. Reset mid-frame discards the partial frame.
- Frame format: HDR_BYTE, ID, DATA, CHK, where CHK = ID ^ DATA.
- FSM states: HUNT, GET_ID, GET_DATA, GET_CHK.
  - HUNT: on rx_valid with rx_data == HDR_BYTE, go to GET_ID. Any other byte stays in HUNT silently.
  - GET_ID: on rx_valid, latch ID, go to GET_DATA. 0xA5 is a legal ID byte here; no resync.
  - GET_DATA: on rx_valid, latch DATA, go to GET_CHK.
  - GET_CHK: on rx_valid, compare rx_data against ID ^ DATA, then return to HUNT.
- Good checksum:
  - ID 0x01: p1_keys <= DATA.
  - ID 0x02: p2_keys <= DATA.
  - ID 0x10: DATA bit0 fires start_pulse; DATA bit1 fires pause_pulse; both may fire in the same cycle.
  - Other IDs: no output change.
  - Any good frame, known ID or not, sets link_ok = 1 and clears the link timer.
- Bad checksum: frame_err pulses, err_cnt increments saturating at 255, keys unchanged.
- Latency: outputs update in the cycle after the CHK byte's rx_valid (1-cycle registered).
- Inter-byte timer:
  - Counts only in GET_ID, GET_DATA and GET_CHK; cleared on every rx_valid and in HUNT.
  - Reaching BYTE_TIMEOUT-1 returns the FSM to HUNT, pulses frame_err and increments err_cnt.
  - If rx_valid arrives in the same cycle as the timeout, the byte wins: it is processed and there is no error.
- Link timer:
  - Free-runs and clears on each good frame.
  - On reaching LINK_TIMEOUT-1: link_ok <= 0, p1_keys <= 0, p2_keys <= 0. The timer holds at that value (no wrap) until the next good frame.
  - If a good frame lands in the same cycle as the link timeout, the frame wins.
- Timer widths are $clog2(TIMEOUT+1). Pulses are never asserted for more than one cycle.

Decomposition:
- Shared package uart_cmd_pkg holds: FSM state encoding, HDR_BYTE, ID constants (ID_P1=8'h01, ID_P2=8'h02, ID_CTRL=8'h10), key bit indices and CTRL bit indices.
- One sub-module is natural: wdog_timer (parameter LIMIT; inputs clear and enable; output expired held high until clear). It is instantiated twice, for the byte timer and the link timer.

Test Plan:
- Bytes A5 01 11 10 with 1-cycle rx_valid strobes -> p1_keys = 8'h11 one cycle after the last strobe, link_ok = 1, frame_err never asserted.
- Bytes A5 02 04 07 (bad CHK) -> frame_err single pulse, err_cnt = 1, p2_keys stays 0; a following A5 02 04 06 sets p2_keys = 8'h04.
- Bytes A5 10 03 13 -> start_pulse and pause_pulse each high for exactly one cycle, in the same cycle.
- Bytes A5 01 then silence for BYTE_TIMEOUT cycles (sim with BYTE_TIMEOUT=50) -> frame_err pulse, FSM back in HUNT; next full frame A5 01 08 09 sets p1_keys = 8'h08.
- After a good frame with p1_keys = 8'h1F, idle LINK_TIMEOUT cycles (sim LINK_TIMEOUT=200) -> link_ok = 0, p1_keys = 0; then 256+ bad frames -> err_cnt stays at 255.
- Assert rstn = 0 after A5 01 mid-frame, release, send 01 11 10 -> no key update; a full frame afterwards is accepted normally.
